// File: rtl/alu_seq_pkg.sv
// Shared constants for the sequential ALU: opcodes, FSM states and NZP flag bit positions.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_REM = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;

endpackage

// File: rtl/alu_seq_step.sv
// One iteration of shift-add multiply (LSB first) or restoring divide (MSB first).
// Purely combinational; the caller owns all state.
module alu_seq_step #(
    parameter int WIDTH = 8
) (
    input  logic                 div_mode_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH:0]       rem_i,
    input  logic [WIDTH-1:0]     quo_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic [WIDTH:0]       rem_o,
    output logic [WIDTH-1:0]     quo_o
);

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;

    // Multiplier sits in the low half of acc and is consumed from bit 0 as the product shifts in.
    always_comb begin
        mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        mul_next = {mul_sum, acc_i[WIDTH-1:1]};
    end

    always_comb begin
        div_shift = {rem_i, quo_i[WIDTH-1]};
        div_ge    = (div_shift >= {2'b00, opnd_i});
        div_diff  = div_shift[WIDTH:0] - {1'b0, opnd_i};
    end

    always_comb begin
        acc_o = acc_i;
        rem_o = rem_i;
        quo_o = quo_i;
        if (div_mode_i) begin
            rem_o = div_ge ? div_diff : div_shift[WIDTH:0];
            quo_o = {quo_i[WIDTH-2:0], div_ge};
        end else begin
            acc_o = mul_next;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle integer ALU with valid/ready handshakes; MUL/DIV/REM iterate one bit per cycle.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  rs,
    input  logic [WIDTH-1:0]  rt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [2:0]        nzp,
    output logic              ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [2:0]           nzp_q, nzp_d;
    logic                 ovf_q, ovf_d;

    logic [2*WIDTH-1:0]   step_acc;
    logic [WIDTH:0]       step_rem;
    logic [WIDTH-1:0]     step_quo;

    alu_seq_step #(.WIDTH(WIDTH)) u_step (
        .div_mode_i (op_q != OP_MUL),
        .acc_i      (acc_q),
        .rem_i      (rem_q),
        .quo_i      (quo_q),
        .opnd_i     (opnd_q),
        .acc_o      (step_acc),
        .rem_o      (step_rem),
        .quo_o      (step_quo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            nzp_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            nzp_q    <= nzp_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        nzp_d    = nzp_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d     = op;
                    cnt_d    = '0;
                    result_d = '0;
                    nzp_d    = '0;
                    ovf_d    = 1'b0;
                    state_d  = ST_DONE;
                    case (op)
                        OP_ADD: {ovf_d, result_d} = {1'b0, rs} + {1'b0, rt};
                        OP_SUB: begin
                            result_d = rs - rt;
                            ovf_d    = (rs < rt);
                        end
                        OP_CMP: begin
                            nzp_d[NZP_N] = (rs < rt);
                            nzp_d[NZP_Z] = (rs == rt);
                            nzp_d[NZP_P] = (rs > rt);
                        end
                        OP_MUL: begin
                            opnd_d  = rs;
                            acc_d   = {{WIDTH{1'b0}}, rt};
                            state_d = ST_BUSY;
                        end
                        OP_DIV, OP_REM: begin
                            // Divide by zero short-circuits to a fixed answer in one cycle.
                            if (rt == '0) begin
                                result_d = (op == OP_DIV) ? '1 : rs;
                                ovf_d    = 1'b1;
                            end else begin
                                opnd_d  = rt;
                                rem_d   = '0;
                                quo_d   = rs;
                                state_d = ST_BUSY;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_BUSY: begin
                acc_d = step_acc;
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = cnt_q;
                    case (op_q)
                        OP_MUL: begin
                            result_d = step_acc[WIDTH-1:0];
                            ovf_d    = |step_acc[2*WIDTH-1:WIDTH];
                        end
                        OP_DIV:  result_d = step_quo;
                        default: result_d = step_rem[WIDTH-1:0];
                    endcase
                end
            end

            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign nzp       = nzp_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed plan cases plus a random stream against an arithmetic model.
module tb_alu_seq;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic [2:0]   nzp;
        logic         ovf;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = '0;
    logic [W-1:0] rs = '0;
    logic [W-1:0] rt = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [2:0]   nzp;
    logic         ovf;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   or_mode = 0;
    bit   seen = 0;
    bit   chk_rdy = 0;
    exp_t sbq[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .nzp       (nzp),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    function automatic exp_t model(input logic [2:0] o, input int a, input int b);
        exp_t e;
        int   m;
        m     = 1 << W;
        e.res = '0;
        e.nzp = '0;
        e.ovf = 1'b0;
        e.lat = 1;
        e.acc = 0;
        case (o)
            3'd0: begin e.res = W'((a + b) % m); e.ovf = ((a + b) >= m); end
            3'd1: begin e.res = W'((a - b + m) % m); e.ovf = (a < b); end
            3'd2: begin e.res = W'((a * b) % m); e.ovf = ((a * b) >= m); e.lat = W + 1; end
            3'd3: begin
                if (b == 0) begin e.res = W'(m - 1); e.ovf = 1'b1; end
                else begin e.res = W'(a / b); e.lat = W + 1; end
            end
            3'd4: begin
                if (b == 0) begin e.res = W'(a); e.ovf = 1'b1; end
                else begin e.res = W'(a % b); e.lat = W + 1; end
            end
            3'd5: e.nzp = (a < b) ? 3'b100 : ((a == b) ? 3'b010 : 3'b001);
            default: ;
        endcase
        return e;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready=%0b want 1 within 200 cycles", in_ready);
        end else begin
            e     = model(o, int'(a), int'(b));
            e.acc = cyc + 1;
            sbq.push_back(e);
            in_valid = 1'b1;
            op       = o;
            rs       = a;
            rt       = b;
            @(negedge clk);
            in_valid = 1'b0;
            rs       = W'($urandom);
            rt       = W'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d want 0", sbq.size());
        end
    endtask

    task automatic expect1(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Monitor: compares the DUT output against the scoreboard head every cycle it is presented.
    always @(negedge clk) begin
        exp_t h;
        int   lat;
        if (!reset) begin
            if (chk_rdy) begin
                chk_rdy = 0;
                checks++;
                if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_after_pop: in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
                end
            end
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: out_valid=1 want 0 (result=%0d)", result);
                end else begin
                    h = sbq[0];
                    if (!seen) begin
                        seen = 1;
                        lat  = cyc - h.acc + 1;
                        checks++;
                        if (lat != h.lat) begin
                            errors++;
                            $display("FAIL latency: got %0d want %0d", lat, h.lat);
                        end
                    end
                    checks++;
                    if (result !== h.res || nzp !== h.nzp || ovf !== h.ovf) begin
                        errors++;
                        $display("FAIL output: result=%0d nzp=%b ovf=%0b want result=%0d nzp=%b ovf=%0b",
                                 result, nzp, ovf, h.res, h.nzp, h.ovf);
                    end
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL ready_in_done: in_ready=%0b want 0", in_ready);
                    end
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        seen    = 0;
                        chk_rdy = 1;
                    end
                end
            end else if (sbq.size() != 0 && cyc >= sbq[0].acc) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_in_busy: in_ready=%0b want 0", in_ready);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;
        int           n;

        #1 reset = 1'b1;
        #2;
        expect1("reset_in_ready", int'(in_ready), 1);
        expect1("reset_out_valid", int'(out_valid), 0);
        expect1("reset_result", int'(result), 0);
        expect1("reset_nzp", int'(nzp), 0);
        expect1("reset_ovf", int'(ovf), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        issue(3'd0, 8'd200, 8'd100);
        issue(3'd1, 8'd5, 8'd9);
        issue(3'd5, 8'd5, 8'd9);
        issue(3'd2, 8'd13, 8'd11);
        issue(3'd2, 8'd20, 8'd20);
        issue(3'd3, 8'd200, 8'd7);
        issue(3'd4, 8'd200, 8'd7);
        issue(3'd3, 8'd77, 8'd0);
        issue(3'd4, 8'd77, 8'd0);
        drain();

        // Backpressure: hold the MUL result for 5 cycles.
        or_mode = 1;
        issue(3'd2, 8'd13, 8'd11);
        n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        expect1("bp_out_valid_seen", int'(out_valid), 1);
        repeat (5) begin
            @(negedge clk);
            expect1("bp_out_valid", int'(out_valid), 1);
            expect1("bp_in_ready", int'(in_ready), 0);
        end
        or_mode = 0;
        drain();

        // Reset in BUSY cycle 4 of a DIV discards it.
        issue(3'd3, 8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        sbq.delete();
        seen    = 0;
        chk_rdy = 0;
        #1;
        expect1("midrst_in_ready", int'(in_ready), 1);
        expect1("midrst_out_valid", int'(out_valid), 0);
        expect1("midrst_result", int'(result), 0);
        expect1("midrst_nzp", int'(nzp), 0);
        expect1("midrst_ovf", int'(ovf), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        expect1("postrst_in_ready", int'(in_ready), 1);
        issue(3'd0, 8'd1, 8'd2);
        drain();

        // Random stream with random out_ready gaps; one slot forced to reserved op 111.
        or_mode = 2;
        for (int i = 0; i < 20; i++) begin
            ro = 3'($urandom_range(0, 7));
            if (i == 10) ro = 3'b111;
            ra = W'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            issue(ro, ra, rb);
        end
        drain();
        or_mode = 0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multi-cycle integer ALU. It is the next generation of the per-lane 8-bit combinational ADD/SUB/MUL/DIV unit.
- Adds REM and CMP, NZP flags, an overflow/divide-by-zero indication and valid/ready handshakes on input and output.
- Replaces the array multiplier/divider with iterative shift-add multiply and restoring divide, trading latency for area.
- Sits between the per-thread register file read stage and the writeback stage of the compute core.

Parameters:
WIDTH, 8, operand/result width in bits (>=4).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
clk  input  1  clock; all state on rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request.
op  input  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 REM, 101 CMP, 110/111 reserved.
rs  input  WIDTH  operand A, unsigned.
rt  input  WIDTH  operand B, unsigned.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
result  output  WIDTH  operation result.
nzp  output  3  {N,Z,P} of rs vs rt (CMP only, else 000).
ovf  output  1  ADD carry-out / SUB borrow / MUL high-half nonzero / DIV,REM divide-by-zero.

Behaviour:
- Reset is asynchronous, active-high: state=IDLE, in_ready=1, out_valid=0, result=0, nzp=0, ovf=0, counter and accumulators=0. Reset mid-operation discards the operation; no output is produced for it.
- States are IDLE, BUSY and DONE.
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
- Accept: in_valid&&in_ready at edge E0 latches op, rs and rt. Inputs are don't-care at all other times.
- Single-cycle ops (ADD, SUB, CMP, reserved, DIV/REM with rt==0): IDLE->DONE at E0, so out_valid is high in the cycle after E0.
- MUL, DIV and REM with rt!=0: IDLE->BUSY at E0. Exactly WIDTH BUSY cycles follow, then BUSY->DONE, so out_valid is high WIDTH+1 cycles after E0.
- DONE: result, nzp and ovf are held stable while out_valid&&!out_ready. On out_ready, DONE->IDLE; in_ready rises the next cycle, so there is no same-cycle re-accept.
- ADD: result = (rs+rt) mod 2^WIDTH; ovf = carry-out.
- SUB: result = (rs-rt) mod 2^WIDTH; ovf = (rs<rt).
- CMP: result = 0; nzp = 100 if rs<rt, 010 if equal, 001 if rs>rt; ovf = 0.
- MUL: shift-add, one multiplier bit per BUSY cycle, LSB first, into a 2*WIDTH accumulator. result = low WIDTH bits; ovf = |high WIDTH bits.
- DIV/REM: restoring division, one quotient bit per BUSY cycle, MSB first, using a (WIDTH+1)-bit partial remainder. DIV returns the quotient; REM returns the remainder. ovf = 0.
- Divide by zero (rt==0): DIV result = all ones; REM result = rs; ovf = 1; single-cycle.
- Reserved op: result = 0, nzp = 0, ovf = 0, single-cycle.
- Counter runs 0..WIDTH-1 in BUSY. The terminal count triggers the DONE transition with no wrap.
- nzp = 000 for all ops other than CMP.

Decomposition:
- Package alu_seq_pkg holds:
  - op localparams: OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_REM, OP_CMP.
  - state encoding: ST_IDLE, ST_BUSY, ST_DONE.
  - NZP bit-index constants.
- One sub-module, alu_seq_step: purely combinational single iteration that computes the next accumulator/partial remainder for MUL or DIV, given mode, current state and operand bit. The FSM, counter and output registers stay in alu_seq.

Test Plan (WIDTH=8):
- ADD 200+100 -> out_valid 1 cycle after accept, result=44, ovf=1. SUB 5-9 -> result=252, ovf=1. CMP 5,9 -> nzp=100, result=0.
- MUL 13*11 -> result=143, ovf=0, out_valid exactly 9 cycles after accept, in_ready=0 throughout. MUL 20*20 -> result=144, ovf=1.
- DIV 200/7 -> result=28. REM 200/7 -> result=4. Both have 9-cycle latency. DIV 77/0 -> 255, ovf=1; REM 77/0 -> 77, ovf=1; both with 1-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles after MUL completes -> result/ovf stable, out_valid=1, in_ready=0. Raise out_ready -> in_ready=1 next cycle.
- Reset asserted asynchronously in BUSY cycle 4 of DIV -> all outputs 0, in_ready=1 after deassert, no out_valid. A following ADD 1+2 -> result=3.
- Back-to-back stream of 20 random ops with random out_ready gaps, checked against a reference model, including reserved op 111 -> result=0, nzp=0, ovf=0.
